// File: rtl/sreg_pkg.sv
// Shared types and constants for the scalar register file writeback path.
package sreg_pkg;

  localparam int NREG    = 8;
  localparam int SREG_AW = 3;
  localparam int SREG_DW = 16;

  typedef enum logic [1:0] {
    WM_FULL = 2'b00,
    WM_LOW  = 2'b01,
    WM_HIGH = 2'b10,
    WM_NONE = 2'b11
  } wb_mode_e;

  typedef struct packed {
    logic [SREG_AW-1:0] addr;
    logic [SREG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding load returns until the sReg write port is free.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when the head leaves on the same edge.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/scalar_wb_ctrl.sv
// Writeback controller: merges ALU results and queued load returns onto the
// single sReg write port and tracks pending loads to stall decode on hazards.
module scalar_wb_ctrl
  import sreg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          AluValid,
  input  logic [AW-1:0] AluAddr,
  input  logic [DW-1:0] AluData,
  input  logic [1:0]    AluMode,
  input  logic          MemValid,
  input  logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemData,
  output logic          MemReady,
  input  logic          IssueValid,
  input  logic          IssueLoad,
  input  logic [AW-1:0] IssueDst,
  input  logic [AW-1:0] IssueSrcA,
  input  logic [AW-1:0] IssueSrcB,
  output logic          Stall,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] DataIn,
  output logic          WR,
  output logic          WR_l,
  output logic          WR_h
);

  localparam int NR = 1 << AW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             alu_wr, pop, fifo_push, fifo_full, fifo_empty;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [CW-1:0]    fifo_count;

  logic [NR-1:0]    busy_q, busy_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             wr_q, wr_d, wr_l_q, wr_l_d, wr_h_q, wr_h_d;

  assign MemReady  = Rst_n && (fifo_count != CW'(DEPTH));
  assign fifo_push = MemValid && !fifo_full;
  assign head_addr = head[AW+DW-1:DW];
  assign head_data = head[DW-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_load_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (fifo_push),
    .pop   (pop),
    .din   ({MemAddr, MemData}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign Stall = IssueValid &&
                 (busy_q[IssueSrcA] || busy_q[IssueSrcB] || busy_q[IssueDst]);

  // The ALU never waits; a queued load only drains on a cycle the ALU leaves free.
  always_comb begin
    alu_wr = AluValid && (wb_mode_e'(AluMode) != WM_NONE);
    pop    = !alu_wr && !fifo_empty;
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = 1'b0;
    wr_l_d = 1'b0;
    wr_h_d = 1'b0;
    if (alu_wr) begin
      addr_d = AluAddr;
      data_d = AluData;
      case (wb_mode_e'(AluMode))
        WM_FULL: wr_d   = 1'b1;
        WM_LOW:  wr_l_d = 1'b1;
        default: wr_h_d = 1'b1;
      endcase
    end else if (pop) begin
      addr_d = head_addr;
      data_d = head_data;
      wr_d   = 1'b1;
    end
  end

  // A new load claiming a register overrides a same-edge release of it.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_addr] = 1'b0;
    if (IssueValid && IssueLoad && !Stall) busy_d[IssueDst] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      wr_l_q <= 1'b0;
      wr_h_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      wr_l_q <= wr_l_d;
      wr_h_q <= wr_h_d;
    end
  end

  assign Addr   = addr_q;
  assign DataIn = data_q;
  assign WR     = wr_q;
  assign WR_l   = wr_l_q;
  assign WR_h   = wr_h_q;

endmodule

// File: tb/tb_scalar_wb_ctrl.sv
// Bench for scalar_wb_ctrl: directed scenarios then random traffic, all checked
// against a queue-based model of the writeback and scoreboard rules.
module tb_scalar_wb_ctrl;
  import sreg_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic [1:0]  alu_mode;
  logic        mem_valid;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic        issue_load;
  logic [2:0]  issue_dst;
  logic [2:0]  issue_src_a;
  logic [2:0]  issue_src_b;
  logic        stall;
  logic [2:0]  addr;
  logic [15:0] data_in;
  logic        wr, wr_l, wr_h;

  int checks = 0;
  int errors = 0;

  wb_entry_t   fifo_m[$];
  bit [7:0]    busy_m;
  logic [2:0]  exp_addr;
  logic [15:0] exp_data;
  logic        exp_wr, exp_wr_l, exp_wr_h;

  scalar_wb_ctrl #(.DEPTH(DEPTH), .DW(16), .AW(3)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .AluValid   (alu_valid),
    .AluAddr    (alu_addr),
    .AluData    (alu_data),
    .AluMode    (alu_mode),
    .MemValid   (mem_valid),
    .MemAddr    (mem_addr),
    .MemData    (mem_data),
    .MemReady   (mem_ready),
    .IssueValid (issue_valid),
    .IssueLoad  (issue_load),
    .IssueDst   (issue_dst),
    .IssueSrcA  (issue_src_a),
    .IssueSrcB  (issue_src_b),
    .Stall      (stall),
    .Addr       (addr),
    .DataIn     (data_in),
    .WR         (wr),
    .WR_l       (wr_l),
    .WR_h       (wr_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_regs();
    check_output("addr", addr, exp_addr);
    check_output("data_in", data_in, exp_data);
    check_output("wr", wr, exp_wr);
    check_output("wr_l", wr_l, exp_wr_l);
    check_output("wr_h", wr_h, exp_wr_h);
  endtask

  task automatic set_idle();
    alu_valid   = 1'b0; alu_addr = '0; alu_data = '0; alu_mode = 2'b00;
    mem_valid   = 1'b0; mem_addr = '0; mem_data = '0;
    issue_valid = 1'b0; issue_load = 1'b0;
    issue_dst   = '0; issue_src_a = '0; issue_src_b = '0;
  endtask

  // One clock: check the combinational outputs, advance the model, check registers.
  task automatic apply_stimulus();
    bit        exp_stall, exp_ready, alu_w;
    wb_entry_t e;
    #2;
    exp_stall = issue_valid && (busy_m[issue_src_a] || busy_m[issue_src_b] || busy_m[issue_dst]);
    exp_ready = (fifo_m.size() != DEPTH);
    check_output("stall", stall, exp_stall);
    check_output("mem_ready", mem_ready, exp_ready);
    alu_w    = alu_valid && (alu_mode != 2'b11);
    exp_wr   = 1'b0;
    exp_wr_l = 1'b0;
    exp_wr_h = 1'b0;
    if (alu_w) begin
      exp_addr = alu_addr;
      exp_data = alu_data;
      exp_wr   = (alu_mode == 2'b00);
      exp_wr_l = (alu_mode == 2'b01);
      exp_wr_h = (alu_mode == 2'b10);
    end else if (fifo_m.size() > 0) begin
      e = fifo_m.pop_front();
      busy_m[e.addr] = 1'b0;
      exp_addr = e.addr;
      exp_data = e.data;
      exp_wr   = 1'b1;
    end
    if (mem_valid && exp_ready) begin
      e.addr = mem_addr;
      e.data = mem_data;
      fifo_m.push_back(e);
    end
    if (issue_valid && issue_load && !exp_stall) busy_m[issue_dst] = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    fifo_m.delete();
    busy_m   = '0;
    exp_addr = '0; exp_data = '0;
    exp_wr   = 1'b0; exp_wr_l = 1'b0; exp_wr_h = 1'b0;
    check_regs();
    check_output("rst_mem_ready", mem_ready, 0);
    @(posedge clk);
    #1;
    check_regs();
    check_output("rst_mem_ready_edge", mem_ready, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    apply_stimulus();

    $display("[TB] ALU write modes");
    for (int m = 0; m < 4; m++) begin
      alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hABCD; alu_mode = m[1:0];
      apply_stimulus();
      check_output("t1_wr", wr, m == 0);
      check_output("t1_wr_l", wr_l, m == 1);
      check_output("t1_wr_h", wr_h, m == 2);
      check_output("t1_addr", addr, 3);
      check_output("t1_data", data_in, 16'hABCD);
    end

    $display("[TB] load hazard stall");
    set_idle();
    issue_valid = 1'b1; issue_load = 1'b1; issue_dst = 3'd5;
    apply_stimulus();
    issue_load = 1'b0; issue_dst = 3'd1; issue_src_a = 3'd5; issue_src_b = 3'd2;
    repeat (3) begin
      apply_stimulus();
      check_output("t2_stall_hold", stall, 1);
    end
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h1234;
    apply_stimulus();
    check_output("t2_stall_hold", stall, 1);
    check_output("t2_no_wr_yet", wr, 0);
    mem_valid = 1'b0;
    apply_stimulus();
    check_output("t2_wr", wr, 1);
    check_output("t2_addr", addr, 5);
    check_output("t2_data", data_in, 16'h1234);
    check_output("t2_stall_drop", stall, 0);
    set_idle();
    apply_stimulus();

    $display("[TB] ALU priority over queued loads");
    alu_valid = 1'b1; alu_mode = 2'b00; alu_addr = 3'd1; alu_data = 16'hA001;
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h1111;
    apply_stimulus();
    check_output("t3_alu1", data_in, 16'hA001);
    alu_data = 16'hA002; mem_addr = 3'd4; mem_data = 16'h2222;
    apply_stimulus();
    mem_valid = 1'b0; alu_data = 16'hA003;
    apply_stimulus();
    check_output("t3_alu3", data_in, 16'hA003);
    alu_valid = 1'b0;
    apply_stimulus();
    check_output("t3_ld1_addr", addr, 2);
    check_output("t3_ld1_data", data_in, 16'h1111);
    apply_stimulus();
    check_output("t3_ld2_addr", addr, 4);
    check_output("t3_ld2_data", data_in, 16'h2222);
    apply_stimulus();
    check_output("t3_idle_wr", wr, 0);

    $display("[TB] FIFO full backpressure");
    set_idle();
    alu_valid = 1'b1; alu_mode = 2'b00; alu_addr = 3'd7; alu_data = 16'h0BAD;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_addr = 3'(i); mem_data = 16'h4000 + 16'(i);
      apply_stimulus();
    end
    check_output("t4_ready_full", mem_ready, 0);
    mem_valid = 1'b0; alu_valid = 1'b0;
    apply_stimulus();
    check_output("t4_ready_after_pop", mem_ready, 1);
    check_output("t4_pop_data", data_in, 16'h4000);
    mem_valid = 1'b1; mem_addr = 3'd4; mem_data = 16'h4004; alu_valid = 1'b1;
    apply_stimulus();
    check_output("t4_refull", mem_ready, 0);
    set_idle();
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus();
      check_output("t4_order", data_in, 16'h4000 + 16'(k));
    end
    apply_stimulus();
    check_output("t4_drained", wr, 0);

    $display("[TB] reset during operation");
    issue_valid = 1'b1; issue_load = 1'b1;
    issue_dst = 3'd1; apply_stimulus();
    issue_dst = 3'd2; apply_stimulus();
    issue_dst = 3'd6; apply_stimulus();
    set_idle();
    alu_valid = 1'b1; alu_mode = 2'b00; mem_valid = 1'b1;
    mem_addr = 3'd1; mem_data = 16'h5001; apply_stimulus();
    mem_addr = 3'd2; mem_data = 16'h5002; apply_stimulus();
    mem_addr = 3'd6; mem_data = 16'h5006; apply_stimulus();
    do_reset();
    issue_valid = 1'b1; issue_src_a = 3'd1; issue_src_b = 3'd2; issue_dst = 3'd6;
    repeat (4) begin
      apply_stimulus();
      check_output("t5_no_stall", stall, 0);
      check_output("t5_no_wr", wr, 0);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      alu_valid   = ($urandom_range(0, 99) < 40);
      alu_addr    = 3'($urandom);
      alu_data    = 16'($urandom);
      alu_mode    = 2'($urandom);
      mem_valid   = ($urandom_range(0, 99) < 45);
      mem_addr    = 3'($urandom);
      mem_data    = 16'($urandom);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_load  = ($urandom_range(0, 3) == 0);
      issue_dst   = 3'($urandom);
      issue_src_a = 3'($urandom);
      issue_src_b = 3'($urandom);
      apply_stimulus();
    end
    set_idle();
    repeat (8) apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
